tap_master: RTL
===============

TAP_MASTER -- requirements
Module: tap_master

Interface
REQ-001 Parameters: none; data width fixed at 32 bits.
REQ-002 CLK  input  1  system clock; all state advances on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high; one clock; reset is asynchronous and active-high.
REQ-004 START  input  1  scan request; sampled only while BUSY=0.
REQ-005 IR_NDR  input  1  1 = instruction scan, 0 = data scan; captured with START.
REQ-006 LEN  input  5  scan length in bits; 1..31 literal, 0 encodes 32; captured with START.
REQ-007 DIN  input  32  bits to shift out, LSB first; captured with START.
REQ-008 TDO_IN  input  1  serial data returned from target TAP.
REQ-009 TCK_OUT  output  1  test clock to target, CLK/2.
REQ-010 TMS_OUT  output  1  test mode select to target.
REQ-011 TDI_OUT  output  1  serial data to target.
REQ-012 DOUT  output  32  captured scan data, right-aligned, first captured bit in DOUT[0].
REQ-013 BUSY  output  1  high while reset sequence or scan in progress.
REQ-014 DONE  output  1  one-CLK pulse on scan completion.

Function
REQ-015 Each TCK period SHALL be 2 CLK: phase 0 TCK_OUT=0, phase 1 TCK_OUT=1; TMS_OUT/TDI_OUT change only on the CLK edge entering phase 0.
REQ-016 TDO_IN SHALL be sampled on the CLK edge that ends phase 0 (TCK_OUT rising), and only for shift-state TCKs.
REQ-017 States: RST_SEQ, IDLE, HDR, SHIFT, POST, FIN.
REQ-018 RST_SEQ: 5 TCKs with TMS=1, then 1 TCK with TMS=0 (target ends in Run-Test/Idle); then IDLE; total 12 CLK after RST deassert.
REQ-019 IDLE: TCK_OUT=0, TMS_OUT=0, TDI_OUT=0; START=1 captures IR_NDR/LEN/DIN, BUSY rises next CLK, enters HDR.
REQ-020 HDR: TMS sequence 1,0,0 for data scan (3 TCK); 1,1,0,0 for instruction scan (4 TCK); TDI_OUT=0.
REQ-021 SHIFT: N TCKs (N=LEN, 32 if LEN=0); TDI_OUT = DIN bit k on k-th TCK; TMS_OUT=0 except 1 on final bit.
REQ-022 Captured bit k SHALL be written to DOUT[k]; DOUT[31:N] SHALL be 0; DOUT updated only when scan completes (FIN), holds otherwise.
REQ-023 POST: TMS sequence 1 (Update), 0 (Run-Test/Idle), 2 TCK.
REQ-024 FIN: DONE=1 for one CLK, BUSY=0 same cycle, return to IDLE; START sampled again from the next CLK.
REQ-025 Latency START to DONE: data scan 2*(N+5)+1 CLK, instruction scan 2*(N+6)+1 CLK.
REQ-026 START while BUSY=1 (including RST_SEQ) SHALL be ignored, not queued.
REQ-027 Input changes on IR_NDR/LEN/DIN after capture SHALL not affect the scan in progress.
REQ-028 Bit counter SHALL be 6 bits wide so N=32 completes without wrap.

Reset
REQ-029 RST=1 at any time, including mid-scan, SHALL immediately force: TCK_OUT=0, TMS_OUT=1, TDI_OUT=0, DOUT=0, DONE=0, BUSY=1, state RST_SEQ, counters 0.
REQ-030 After RST deassert the RST_SEQ of REQ-018 SHALL run before any START is accepted; an aborted scan produces no DONE.

Verification
REQ-031 Release RST -> TMS_OUT=1 for 5 TCK rising edges, 0 for 1, then BUSY=0 at CLK 12 after release.
REQ-032 Data scan LEN=8, DIN=0xA5, TDO_IN looped from TDI_OUT one TCK later via a 1-bit target model -> TMS 1,0,0,0x7,1,1,0; DONE at CLK 27 after START; DOUT=0x000000A5 (model-adjusted).
REQ-033 Instruction scan LEN=4, DIN=0x3, TDO_IN tied 1 -> TMS 1,1,0,0,0,0,0,1,1,0; DOUT=0x0000000F; DONE at CLK 21.
REQ-034 LEN=0, DIN=0xDEADBEEF, bypass-style target model (1-bit delay) -> 32 shift TCKs, no counter wrap, DOUT = DIN shifted by one with bit 0 = capture value.
REQ-035 START pulsed during scan and during RST_SEQ -> no extra scan, exactly one DONE per accepted START.
REQ-036 RST asserted at shift bit 10 of a 32-bit scan -> outputs at reset values same cycle, no DONE, full RST_SEQ replayed, next scan correct.

Source files
------------

// File: rtl/tap_master.sv
// tap_master: JTAG TAP scan master.
// Drives a target TAP through a reset walk into Run-Test/Idle, then performs
// single IR or DR scans of 1..32 bits on request.  TCK runs at CLK/2; TMS/TDI
// are launched on the edge that drops TCK and TDO is sampled on the edge that
// raises TCK.
//
// Ports:
//   clk_i      system clock, all state on rising edge
//   rst_i      asynchronous active-high reset
//   start_i    scan request, accepted only while busy_o=0
//   ir_ndr_i   1 = instruction scan, 0 = data scan (captured with start_i)
//   len_i      scan length, 1..31, 0 encodes 32 (captured with start_i)
//   din_i      bits to shift out, LSB first (captured with start_i)
//   tdo_in_i   serial data returned by the target
//   tck_out_o  test clock to target
//   tms_out_o  test mode select to target
//   tdi_out_o  serial data to target
//   dout_o     captured scan data, first captured bit in dout_o[0]
//   busy_o     high during reset walk or scan
//   done_o     one-clock pulse when a scan completes
module tap_master (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        ir_ndr_i,
  input  logic [4:0]  len_i,
  input  logic [31:0] din_i,
  input  logic        tdo_in_i,
  output logic        tck_out_o,
  output logic        tms_out_o,
  output logic        tdi_out_o,
  output logic [31:0] dout_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    RST_SEQ = 3'd0,
    IDLE    = 3'd1,
    HDR     = 3'd2,
    SHIFT   = 3'd3,
    POST    = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        ph_q, ph_d;        // TCK phase, doubles as the TCK output
  logic [5:0]  cnt_q, cnt_d;      // TCKs completed in the current state
  logic        ir_q, ir_d;
  logic [5:0]  len_q, len_d;      // decoded length 1..32
  logic [31:0] din_q, din_d;
  logic [31:0] cap_q, cap_d;      // capture buffer, published to dout at FIN
  logic [31:0] dout_q, dout_d;
  logic        tms_q, tms_d;
  logic        tdi_q, tdi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [5:0]  hdr_last_s;        // index of the last header TCK
  logic [4:0]  nxt_idx_s;         // next shift bit index

  // Next-state and output logic; ph_q=1 marks the edge that ends a TCK.
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    cnt_d      = cnt_q;
    ir_d       = ir_q;
    len_d      = len_q;
    din_d      = din_q;
    cap_d      = cap_q;
    dout_d     = dout_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hdr_last_s = ir_q ? 6'd3 : 6'd2;
    nxt_idx_s  = cnt_q[4:0] + 5'd1;

    case (state_q)
      RST_SEQ: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          if (cnt_q == 6'd5) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
            tms_d   = 1'b0;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 6'd1;
            // TCKs 0..4 walk Test-Logic-Reset, TCK 5 enters Run-Test/Idle
            tms_d = (cnt_q < 6'd4);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      IDLE, FIN: begin
        ph_d  = 1'b0;
        cnt_d = 6'd0;
        tms_d = 1'b0;
        tdi_d = 1'b0;
        if (start_i) begin
          state_d = HDR;
          ir_d    = ir_ndr_i;
          len_d   = (len_i == 5'd0) ? 6'd32 : {1'b0, len_i};
          din_d   = din_i;
          cap_d   = 32'd0;
          tms_d   = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      HDR: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          if (cnt_q == hdr_last_s) begin
            state_d = SHIFT;
            cnt_d   = 6'd0;
            tms_d   = (len_q == 6'd1);
            tdi_d   = din_q[0];
          end else begin
            cnt_d = cnt_q + 6'd1;
            // only the IR walk has a second TMS=1 (Select-IR-Scan)
            tms_d = ir_q && (cnt_q == 6'd0);
            tdi_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      SHIFT: begin
        ph_d = ~ph_q;
        if (!ph_q) begin
          // rising TCK: take the target's bit for this shift position
          cap_d[cnt_q[4:0]] = tdo_in_i;
        end else if (cnt_q == len_q - 6'd1) begin
          state_d = POST;
          cnt_d   = 6'd0;
          tms_d   = 1'b1;
          tdi_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 6'd1;
          tdi_d = din_q[nxt_idx_s];
          tms_d = ((cnt_q + 6'd2) == len_q);
        end
      end

      POST: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          if (cnt_q == 6'd1) begin
            state_d = FIN;
            cnt_d   = 6'd0;
            tms_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            dout_d  = cap_q;
          end else begin
            cnt_d = cnt_q + 6'd1;
            tms_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      default: begin
        state_d = RST_SEQ;
        ph_d    = 1'b0;
        cnt_d   = 6'd0;
        tms_d   = 1'b1;
        tdi_d   = 1'b0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // State and output registers; reset restarts the TAP reset walk.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RST_SEQ;
      ph_q    <= 1'b0;
      cnt_q   <= 6'd0;
      ir_q    <= 1'b0;
      len_q   <= 6'd0;
      din_q   <= 32'd0;
      cap_q   <= 32'd0;
      dout_q  <= 32'd0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      len_q   <= len_d;
      din_q   <= din_d;
      cap_q   <= cap_d;
      dout_q  <= dout_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tck_out_o = ph_q;
  assign tms_out_o = tms_q;
  assign tdi_out_o = tdi_q;
  assign dout_o    = dout_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule
